// File: rtl/and_run_if.sv
// Bus between the AND-stage run monitor and its environment: run input,
// clear strobe, report handshake and status outputs.
interface and_run_if #(
    parameter int unsigned CNT_W = 8
);
    logic             y_in;
    logic             clear;
    logic             rpt_ready;
    logic             rpt_valid;
    logic [CNT_W-1:0] rpt_len;
    logic [CNT_W-1:0] event_cnt;
    logic             overflow;
    logic             busy;

    // Environment side: drives the run input, clear and report acceptance
    modport master (
        output y_in,
        output clear,
        output rpt_ready,
        input  rpt_valid,
        input  rpt_len,
        input  event_cnt,
        input  overflow,
        input  busy
    );

    // Monitor side
    modport slave (
        input  y_in,
        input  clear,
        input  rpt_ready,
        output rpt_valid,
        output rpt_len,
        output event_cnt,
        output overflow,
        output busy
    );
endinterface

// File: rtl/and_run_monitor.sv
// Measures contiguous high runs of the AND-stage output. Runs of at least
// MIN_RUN cycles are counted and offered through a one-entry valid/ready
// report register; qualifying runs that find the slot occupied are dropped
// and flagged in a sticky overflow bit.
module and_run_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MIN_RUN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    and_run_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_LEN   = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] run_len_q,   run_len_d;
    logic             rpt_valid_q, rpt_valid_d;
    logic [CNT_W-1:0] rpt_len_q,   rpt_len_d;
    logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
    logic             overflow_q,  overflow_d;
    logic             busy_q,      busy_d;

    logic             xfer_c;
    logic             run_end_c;
    logic             qualify_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_len_q   <= CNT_ZERO;
            rpt_valid_q <= 1'b0;
            rpt_len_q   <= CNT_ZERO;
            event_cnt_q <= CNT_ZERO;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_len_q   <= rpt_len_d;
            event_cnt_q <= event_cnt_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state: run measurement, report slot management and clear
    always_comb begin
        state_d     = state_q;
        run_len_d   = run_len_q;
        rpt_valid_d = rpt_valid_q;
        rpt_len_d   = rpt_len_q;
        event_cnt_d = event_cnt_q;
        overflow_d  = overflow_q;
        xfer_c      = 1'b0;
        run_end_c   = 1'b0;
        qualify_c   = 1'b0;

        if (bus.clear) begin
            state_d     = IDLE;
            run_len_d   = CNT_ZERO;
            rpt_valid_d = 1'b0;
            rpt_len_d   = CNT_ZERO;
            event_cnt_d = CNT_ZERO;
            overflow_d  = 1'b0;
        end else begin
            xfer_c = rpt_valid_q && bus.rpt_ready;
            if (xfer_c) begin
                rpt_valid_d = 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.y_in) begin
                        run_len_d = CNT_ONE;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (bus.y_in) begin
                        // A saturated run keeps running at CNT_MAX
                        if (run_len_q != CNT_MAX) begin
                            run_len_d = run_len_q + CNT_ONE;
                        end
                    end else begin
                        run_end_c = 1'b1;
                        run_len_d = CNT_ZERO;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    run_len_d = CNT_ZERO;
                end
            endcase

            qualify_c = run_end_c && (run_len_q >= MIN_LEN);
            if (qualify_c) begin
                if (event_cnt_q != CNT_MAX) begin
                    event_cnt_d = event_cnt_q + CNT_ONE;
                end
                // Slot is free if empty or being drained on this same edge
                if (!rpt_valid_q || xfer_c) begin
                    rpt_valid_d = 1'b1;
                    rpt_len_d   = run_len_q;
                end else begin
                    overflow_d  = 1'b1;
                end
            end
        end
    end

    // busy tracks the registered FSM state
    always_comb begin
        busy_d = (state_d == RUN);
    end

    assign bus.rpt_valid = rpt_valid_q;
    assign bus.rpt_len   = rpt_len_q;
    assign bus.event_cnt = event_cnt_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_and_run_monitor.sv
// Directed bench for and_run_monitor with CNT_W=4, MIN_RUN=3.
module tb_and_run_monitor;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned MIN_RUN = 3;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    and_run_if #(.CNT_W(CNT_W)) bus ();

    and_run_monitor #(.CNT_W(CNT_W), .MIN_RUN(MIN_RUN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, settle 1 time unit after it
    task automatic cyc(input logic y, input logic rdy);
        bus.y_in      = y;
        bus.rpt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(bus.rpt_valid), 0);
        chk({tag, "_len"},   int'(bus.rpt_len),   0);
        chk({tag, "_evt"},   int'(bus.event_cnt), 0);
        chk({tag, "_ovf"},   int'(bus.overflow),  0);
        chk({tag, "_busy"},  int'(bus.busy),      0);
    endtask

    task automatic do_clear(input logic y);
        bus.clear = 1'b1;
        cyc(y, 1'b0);
        bus.clear = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.y_in      = 1'b0;
        bus.clear     = 1'b0;
        bus.rpt_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero("por");
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk_zero("post_rst_idle");

        // Qualifying run of 5, held report then accepted
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
        chk("q5_busy", int'(bus.busy), 1);
        chk("q5_novalid", int'(bus.rpt_valid), 0);
        cyc(1'b0, 1'b0);
        chk("q5_valid", int'(bus.rpt_valid), 1);
        chk("q5_len",   int'(bus.rpt_len),   5);
        chk("q5_evt",   int'(bus.event_cnt), 1);
        chk("q5_busy0", int'(bus.busy),      0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            chk("q5_hold_valid", int'(bus.rpt_valid), 1);
            chk("q5_hold_len",   int'(bus.rpt_len),   5);
        end
        cyc(1'b0, 1'b1);
        chk("q5_taken", int'(bus.rpt_valid), 0);
        chk("q5_evt_keep", int'(bus.event_cnt), 1);

        // Short runs after clear: nothing reported
        do_clear(1'b0);
        chk_zero("clr1");
        cyc(1'b1, 1'b0);
        chk("s_busy_a", int'(bus.busy), 1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("s_busy_b", int'(bus.busy), 0);
        chk("s_valid_b", int'(bus.rpt_valid), 0);
        cyc(1'b1, 1'b0);
        chk("s_busy_c", int'(bus.busy), 1);
        cyc(1'b0, 1'b0);
        chk("s_busy_d", int'(bus.busy), 0);
        chk("s_valid_d", int'(bus.rpt_valid), 0);
        chk("s_evt", int'(bus.event_cnt), 0);

        // Overflow: run 4 pending, run 3 dropped
        do_clear(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("o_len4", int'(bus.rpt_len), 4);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("o_evt",   int'(bus.event_cnt), 2);
        chk("o_ovf",   int'(bus.overflow),  1);
        chk("o_len",   int'(bus.rpt_len),   4);
        chk("o_valid", int'(bus.rpt_valid), 1);

        // Simultaneous transfer and reload on the run-end edge
        do_clear(1'b0);
        chk("sim_ovf_clr", int'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk("sim_valid", int'(bus.rpt_valid), 1);
        chk("sim_len",   int'(bus.rpt_len),   3);
        chk("sim_ovf",   int'(bus.overflow),  0);
        chk("sim_evt",   int'(bus.event_cnt), 2);
        cyc(1'b0, 1'b1);
        chk("sim_drain", int'(bus.rpt_valid), 0);

        // Asynchronous reset mid-run with a report pending
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("pre_rst_valid", int'(bus.rpt_valid), 1);
        chk("pre_rst_busy",  int'(bus.busy),      1);
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        chk_zero("rst_release");

        // Saturation of run length
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        chk("sat_busy", int'(bus.busy), 1);
        cyc(1'b0, 1'b0);
        chk("sat_len", int'(bus.rpt_len),   15);
        chk("sat_evt", int'(bus.event_cnt), 1);

        // Event counter saturation: 16 more qualifying runs, always ready
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b1);
        end
        chk("evt_sat",       int'(bus.event_cnt), 15);
        chk("evt_sat_ovf",   int'(bus.overflow),  0);
        chk("evt_sat_len",   int'(bus.rpt_len),   3);
        chk("evt_sat_valid", int'(bus.rpt_valid), 1);

        // Clear in the middle of a run with y_in still high
        do_clear(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        chk("cm_busy", int'(bus.busy), 1);
        do_clear(1'b1);
        chk_zero("cm_clr");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("cm_busy2", int'(bus.busy), 1);
        cyc(1'b0, 1'b0);
        chk("cm_valid", int'(bus.rpt_valid), 1);
        chk("cm_len",   int'(bus.rpt_len),   3);
        chk("cm_evt",   int'(bus.event_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
